// File: rtl/sgd_update_ctrl.sv
// ----------------------------------------------------------------------------
// sgd_update_ctrl
//   Read/write-back sequencer for the SIZE-lane SGD weight-update datapath
//   (w - in*x per lane). One pass walks the chunk address from 0 up to
//   num_chunks-1. Each cycle it issues one read to the w, in and x buffers.
//   The matching write-back strobe appears PIPE = RD_LAT + OP_LAT cycles
//   after the read.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     start           begin a pass (sampled only in IDLE)
//     num_chunks      chunk count, captured on an accepted start
//     pause           suppresses new read issue while high
//     rd_en, rd_addr  registered read strobe / chunk address
//     wr_en, wr_addr  registered write-back strobe / chunk address
//     busy            high from the cycle after an accepted start until done
//     done            single-cycle completion pulse
//
//   Optional feature (macro SGD_CTRL_EPOCHS_EN)
//     num_epochs      number of passes per start, captured with start
//                     (0 behaves as 1)
//     epoch           index of the current pass
//
//   RD_LAT must lie in 1..3 and OP_LAT must be at least 1, so PIPE >= 2.
// ----------------------------------------------------------------------------
module sgd_update_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1,
  parameter int OP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_chunks,
  input  logic              pause,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
`ifdef SGD_CTRL_EPOCHS_EN
  ,
  input  logic [7:0]        num_epochs,
  output logic [7:0]        epoch
`endif
);

  localparam int PIPE = RD_LAT + OP_LAT;
  // rd_en and wr_en are both registers. That leaves PIPE-1 delay stages
  // between them.
  localparam int DLY  = PIPE - 1;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] nc_q, nc_d;
  logic              rd_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              pipe_empty;

  logic              vld_p  [DLY];
  logic [ADDR_W-1:0] addr_p [DLY];

`ifdef SGD_CTRL_EPOCHS_EN
  logic [7:0] ne_q, ne_d, epoch_d;
  logic       ep_more;
  // Compare at 9 bits so that epoch = 255 cannot overflow. This also makes
  // num_epochs = 0 act like 1.
  assign ep_more = ({1'b0, epoch} + 9'd1) < {1'b0, ne_q};
`endif

  // The pipe is empty when no issued read is still waiting to be written
  // back. That covers the read on rd_en now and every delay stage.
  always_comb begin
    pipe_empty = !rd_en;
    for (int i = 0; i < DLY; i++) begin
      if (vld_p[i]) pipe_empty = 1'b0;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    nc_d      = nc_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    busy_d    = busy;
    done_d    = 1'b0;
`ifdef SGD_CTRL_EPOCHS_EN
    ne_d      = ne_q;
    epoch_d   = epoch;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          nc_d  = num_chunks;
          cnt_d = '0;
`ifdef SGD_CTRL_EPOCHS_EN
          ne_d    = num_epochs;
          epoch_d = '0;
`endif
          if (num_chunks != '0) begin
            state_d = ISSUE;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!pause) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt;
          cnt_d     = cnt + ONE;
          if (cnt == nc_q - ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
`ifdef SGD_CTRL_EPOCHS_EN
          if (ep_more) begin
            state_d = ISSUE;
            cnt_d   = '0;
            epoch_d = epoch + 8'd1;
          end else
`endif
          begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: FSM, counter and registered read-side outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      nc_q    <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SGD_CTRL_EPOCHS_EN
      ne_q    <= '0;
      epoch   <= '0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      nc_q    <= nc_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef SGD_CTRL_EPOCHS_EN
      ne_q    <= ne_d;
      epoch   <= epoch_d;
`endif
    end
  end

  // ---- stages p1..pPIPE: read-to-write delay line and write-back outputs ----
  // Reset clears the delay line, so writes in flight when reset arrives
  // are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) begin
        vld_p[i]  <= 1'b0;
        addr_p[i] <= '0;
      end
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      vld_p[0]  <= rd_en;
      addr_p[0] <= rd_addr;
      for (int i = 1; i < DLY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
      wr_en <= vld_p[DLY-1];
      if (vld_p[DLY-1]) wr_addr <= addr_p[DLY-1];
    end
  end

endmodule

// File: tb/tb_sgd_update_ctrl.sv
module tb_sgd_update_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_chunks;
  logic       pause;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       busy;
  logic       done;
`ifdef SGD_CTRL_EPOCHS_EN
  logic [7:0] num_epochs;
  logic [7:0] epoch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sgd_update_ctrl #(.ADDR_W(8), .RD_LAT(1), .OP_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_chunks (num_chunks),
    .pause      (pause),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done)
`ifdef SGD_CTRL_EPOCHS_EN
    ,
    .num_epochs (num_epochs),
    .epoch      (epoch)
`endif
  );

  typedef struct {
    logic       start;
    logic [7:0] nc;
    logic       pause;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int s, input int nc, input int p, input int re, input int ra,
                     input int we, input int wa, input int b, input int d);
    vec_t v;
    v.start   = (s != 0);
    v.nc      = nc[7:0];
    v.pause   = (p != 0);
    v.rd_en   = (re != 0);
    v.rd_addr = ra[7:0];
    v.wr_en   = (we != 0);
    v.wr_addr = wa[7:0];
    v.busy    = (b != 0);
    v.done    = (d != 0);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_cyc[$], rd_a[$], wr_cyc[$], wr_a[$];
    int dones, wr_seen, done_seen;
    bit fin;

    rst_n = 1'b0; start = 1'b0; num_chunks = '0; pause = 1'b0;
`ifdef SGD_CTRL_EPOCHS_EN
    num_epochs = 8'd1;
`endif
    #2;
    chk("reset.rd_en", int'(rd_en), 0);
    chk("reset.wr_en", int'(wr_en), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.rd_addr", int'(rd_addr), 0);
    chk("reset.wr_addr", int'(wr_addr), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Columns: start nc pause | rd_en rd_addr wr_en wr_addr busy done
    // Basic pass of 4 chunks.
    add(1,4,0, 0,0,0,0,1,0);
    add(0,0,0, 1,0,0,0,1,0);
    add(0,0,0, 1,1,0,0,1,0);
    add(0,0,0, 1,2,1,0,1,0);
    add(0,0,0, 1,3,1,1,1,0);
    add(0,0,0, 0,3,1,2,1,0);
    add(0,0,0, 0,3,1,3,1,0);
    add(0,0,0, 0,3,0,3,0,1);
    add(0,0,0, 0,3,0,3,0,0);
    // Zero-length pass.
    add(1,0,0, 0,3,0,3,0,1);
    add(0,0,0, 0,3,0,3,0,0);
    // Pass of 3 chunks with a start of 9 chunks ignored during ISSUE.
    add(1,3,0, 0,3,0,3,1,0);
    add(1,9,0, 1,0,0,3,1,0);
    add(0,0,0, 1,1,0,3,1,0);
    add(0,0,0, 1,2,1,0,1,0);
    add(0,0,0, 0,2,1,1,1,0);
    add(0,0,0, 0,2,1,2,1,0);
    add(0,0,0, 0,2,0,2,0,1);
    // A start during the done cycle is ignored; the next one is accepted.
    add(1,2,0, 0,2,0,2,0,0);
    add(1,1,0, 0,2,0,2,1,0);
    add(0,0,0, 1,0,0,2,1,0);
    add(0,0,0, 0,0,0,2,1,0);
    add(0,0,0, 0,0,1,0,1,0);
    add(0,0,0, 0,0,0,0,0,1);
    add(0,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; num_chunks = vq[i].nc; pause = vq[i].pause;
      step();
      chk($sformatf("row%0d.rd_en", i),   int'(rd_en),   int'(vq[i].rd_en));
      chk($sformatf("row%0d.rd_addr", i), int'(rd_addr), int'(vq[i].rd_addr));
      chk($sformatf("row%0d.wr_en", i),   int'(wr_en),   int'(vq[i].wr_en));
      chk($sformatf("row%0d.wr_addr", i), int'(wr_addr), int'(vq[i].wr_addr));
      chk($sformatf("row%0d.busy", i),    int'(busy),    int'(vq[i].busy));
      chk($sformatf("row%0d.done", i),    int'(done),    int'(vq[i].done));
    end
    start = 1'b0;

    // Pause: 5 chunks, read issue held off for 3 cycles after the 2nd read.
    num_chunks = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0; fin = 1'b0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      pause = (c >= 3 && c <= 5);
      step();
      if (rd_en) begin rd_cyc.push_back(c); rd_a.push_back(int'(rd_addr)); end
      if (wr_en) begin wr_cyc.push_back(c); wr_a.push_back(int'(wr_addr)); end
      if (done) begin dones++; fin = 1'b1; end
    end
    pause = 1'b0;
    chk("pause.finished", int'(fin), 1);
    chk("pause.reads", rd_a.size(), 5);
    chk("pause.writes", wr_a.size(), 5);
    chk("pause.dones", dones, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pause.rd_addr%0d", i), (i < rd_a.size()) ? rd_a[i] : -1, i);
      chk($sformatf("pause.wr_addr%0d", i), (i < wr_a.size()) ? wr_a[i] : -1, i);
      chk($sformatf("pause.lat%0d", i),
          (i < wr_cyc.size() && i < rd_cyc.size()) ? wr_cyc[i] - rd_cyc[i] : -1, 2);
    end
    chk("pause.gap", (rd_cyc.size() >= 3) ? rd_cyc[2] - rd_cyc[1] : -1, 4);
    step();

    // Reset two cycles into an 8-chunk pass.
    num_chunks = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("rstmid.pre_rd_en", int'(rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.rd_en", int'(rd_en), 0);
    chk("rstmid.rd_addr", int'(rd_addr), 0);
    chk("rstmid.wr_en", int'(wr_en), 0);
    chk("rstmid.wr_addr", int'(wr_addr), 0);
    chk("rstmid.busy", int'(busy), 0);
    chk("rstmid.done", int'(done), 0);
    step();
    step();
    rst_n = 1'b1;
    wr_seen = 0; done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (wr_en || rd_en) wr_seen++;
      if (done || busy) done_seen++;
    end
    chk("rstmid.no_strobes", wr_seen, 0);
    chk("rstmid.no_done", done_seen, 0);
    num_chunks = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      step();
      if (done) fin = 1'b1;
    end
    chk("rstmid.restart_done", int'(fin), 1);
    step();

`ifdef SGD_CTRL_EPOCHS_EN
    // Epochs: 2 chunks x 3 epochs, one done at the end.
    rd_a.delete(); rd_cyc.delete();
    num_chunks = 8'd2; num_epochs = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("epoch.start", int'(epoch), 0);
    dones = 0; fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      step();
      if (rd_en) begin rd_a.push_back(int'(rd_addr)); rd_cyc.push_back(int'(epoch)); end
      if (done) begin dones++; fin = 1'b1; end
    end
    chk("epoch.finished", int'(fin), 1);
    chk("epoch.dones", dones, 1);
    chk("epoch.reads", rd_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("epoch.rd_addr%0d", i), (i < rd_a.size()) ? rd_a[i] : -1, i % 2);
      chk($sformatf("epoch.idx%0d", i), (i < rd_cyc.size()) ? rd_cyc[i] : -1, i / 2);
    end
    num_epochs = 8'd1;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
